// File: rtl/cms_pkg.sv
// Shared constants for the trace packetizer: control register map,
// capture mode encoding and tdata field offset helpers.
package cms_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_RANGE = 2'd2
  } mode_e;

  localparam int CTRL_MODE  = 0;
  localparam int CTRL_PC_LO = 1;
  localparam int CTRL_PC_HI = 2;
  localparam int CTRL_TLAST = 3;
  localparam int CTRL_HALT  = 4;

  localparam int INSTR_W = 32;
  localparam int PC_LSB  = INSTR_W;

  function automatic int ev_lsb(int xlen, int cnt_w, int idx);
    return PC_LSB + xlen + idx * cnt_w;
  endfunction

  function automatic int pkt_bits(int xlen, int n_ev, int cnt_w);
    return PC_LSB + xlen + n_ev * cnt_w;
  endfunction

endpackage

// File: rtl/cms_event_counter_bank.sv
// Saturating per-event counters; snap_o includes this cycle's events.
// Ports: clk/rst, en_i gate, events_i pulses, clear_i on capture, snap_o.
module cms_event_counter_bank #(
  parameter int NUM_EVENTS = 39,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_i,
  input  logic [NUM_EVENTS-1:0]           events_i,
  input  logic                            clear_i,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0] snap_o
);

  localparam int W = NUM_EVENTS * CNT_WIDTH;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (en_i && events_i[i] &&
          (cnt_q[i*CNT_WIDTH +: CNT_WIDTH] != '1)) begin
        cnt_d[i*CNT_WIDTH +: CNT_WIDTH] =
          cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      end
    end
  end

  assign snap_o = cnt_d;

  // The snapshot already holds this cycle's events, so clearing
  // on capture loses nothing.
  always_ff @(posedge clk) begin
    if (rst || clear_i) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cms_trace_packetizer.sv
// Packs retired instr/pc plus event counts into one AXI-Stream beat.
// Ports: retire/event inputs, control write port, M_AXIS, halt_cpu, stats.
module cms_trace_packetizer
  import cms_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int NUM_EVENTS      = 39,
  parameter int CNT_WIDTH       = 7,
  parameter int AXI_DATA_WIDTH  = 1024,
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                instr,
  input  logic [XLEN-1:0]            pc,
  input  logic                       pc_valid,
  input  logic [NUM_EVENTS-1:0]      performance_events,
  input  logic                       en,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                       ctrl_write_enable,
  output logic                       M_AXIS_tvalid,
  output logic [AXI_DATA_WIDTH-1:0]  M_AXIS_tdata,
  output logic                       M_AXIS_tlast,
  input  logic                       M_AXIS_tready,
  output logic                       halt_cpu,
  output logic [63:0]                item_counter,
  output logic [63:0]                dropped_counter,
  output logic [63:0]                halted_cycles
);

  if (pkt_bits(XLEN, NUM_EVENTS, CNT_WIDTH) > AXI_DATA_WIDTH) begin : g_chk
    $error("packet does not fit in AXI_DATA_WIDTH");
  end

  localparam int EVW     = NUM_EVENTS * CNT_WIDTH;
  localparam int EV_BASE = ev_lsb(XLEN, CNT_WIDTH, 0);

  localparam logic [CTRL_ADDR_WIDTH-1:0] A_MODE  = CTRL_ADDR_WIDTH'(CTRL_MODE);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_LO    = CTRL_ADDR_WIDTH'(CTRL_PC_LO);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_HI    = CTRL_ADDR_WIDTH'(CTRL_PC_HI);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_TLAST = CTRL_ADDR_WIDTH'(CTRL_TLAST);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_HALT  = CTRL_ADDR_WIDTH'(CTRL_HALT);

  logic                      we_q;
  logic                      wr_pulse;
  mode_e                     mode_q;
  logic [XLEN-1:0]           pc_lo_q, pc_hi_q;
  logic [31:0]               tlast_int_q;
  logic                      halt_en_q;
  logic [31:0]               pkt_q, pkt_d, pkt_inc;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d, pack;
  logic [63:0]               items_q, drop_q, halt_q;
  logic                      in_range, capture, hs, accept, drop;
  logic [EVW-1:0]            snap;
  logic                      ctrl_unused;

  assign ctrl_unused = ^ctrl_wdata;
  assign wr_pulse    = ctrl_write_enable & ~we_q;

  assign in_range = (pc >= pc_lo_q) && (pc <= pc_hi_q);
  assign capture  = en && pc_valid &&
                    ((mode_q == MODE_ALL) ||
                     ((mode_q == MODE_RANGE) && in_range));
  assign hs       = tvalid_q && M_AXIS_tready;
  // A slot emptied this cycle can be refilled without a bubble.
  assign accept   = capture && (!tvalid_q || M_AXIS_tready);
  assign drop     = capture && tvalid_q && !M_AXIS_tready;

  cms_event_counter_bank #(
    .NUM_EVENTS(NUM_EVENTS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .events_i(performance_events),
    .clear_i (accept),
    .snap_o  (snap)
  );

  always_comb begin
    pack                   = '0;
    pack[31:0]             = instr;
    pack[PC_LSB +: XLEN]   = pc;
    pack[EV_BASE +: EVW]   = snap;
  end

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    pkt_d    = pkt_q;
    pkt_inc  = pkt_q + 32'd1;
    if (hs) tvalid_d = 1'b0;
    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = pack;
      tlast_d  = (tlast_int_q != 32'd0) && (pkt_inc == tlast_int_q);
      pkt_d    = tlast_d ? 32'd0 : pkt_inc;
    end
    if (wr_pulse && (ctrl_addr == A_TLAST)) pkt_d = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      mode_q      <= MODE_OFF;
      pc_lo_q     <= '0;
      pc_hi_q     <= '1;
      tlast_int_q <= '0;
      halt_en_q   <= 1'b0;
      pkt_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      items_q     <= '0;
      drop_q      <= '0;
      halt_q      <= '0;
    end else begin
      we_q     <= ctrl_write_enable;
      pkt_q    <= pkt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      items_q  <= items_q + 64'(hs);
      drop_q   <= drop_q + 64'(drop);
      halt_q   <= halt_q + 64'(halt_cpu);
      if (wr_pulse) begin
        case (ctrl_addr)
          A_MODE:  mode_q      <= mode_e'(ctrl_wdata[1:0]);
          A_LO:    pc_lo_q     <= XLEN'(ctrl_wdata);
          A_HI:    pc_hi_q     <= XLEN'(ctrl_wdata);
          A_TLAST: tlast_int_q <= 32'(ctrl_wdata);
          A_HALT:  halt_en_q   <= ctrl_wdata[0];
          default: ;
        endcase
      end
    end
  end

  assign halt_cpu = !rst && halt_en_q && (mode_q != MODE_OFF) &&
                    tvalid_q && !M_AXIS_tready;

  assign M_AXIS_tvalid   = tvalid_q;
  assign M_AXIS_tdata    = tdata_q;
  assign M_AXIS_tlast    = tlast_q;
  assign item_counter    = items_q;
  assign dropped_counter = drop_q;
  assign halted_cycles   = halt_q;

endmodule

// File: tb/tb_cms_trace_packetizer.sv
// Scoreboard bench for cms_trace_packetizer with a behavioural model.
// Directed scenarios followed by a randomized traffic phase.
module tb_cms_trace_packetizer;

  localparam int XL  = 64;
  localparam int NE  = 39;
  localparam int CW  = 7;
  localparam int DW  = 1024;
  localparam int AW  = 8;
  localparam int CDW = 64;
  localparam int EVB = 32 + XL;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    instr = '0;
  logic [XL-1:0]  pc = '0;
  logic           pc_valid = 1'b0;
  logic [NE-1:0]  performance_events = '0;
  logic           en = 1'b1;
  logic [AW-1:0]  ctrl_addr = '0;
  logic [CDW-1:0] ctrl_wdata = '0;
  logic           ctrl_write_enable = 1'b0;
  logic           tvalid, tlast, tready = 1'b0, halt;
  logic [DW-1:0]  tdata;
  logic [63:0]    item_counter, dropped_counter, halted_cycles;

  always #5 clk = ~clk;

  cms_trace_packetizer dut (
    .clk               (clk),
    .rst               (rst),
    .instr             (instr),
    .pc                (pc),
    .pc_valid          (pc_valid),
    .performance_events(performance_events),
    .en                (en),
    .ctrl_addr         (ctrl_addr),
    .ctrl_wdata        (ctrl_wdata),
    .ctrl_write_enable (ctrl_write_enable),
    .M_AXIS_tvalid     (tvalid),
    .M_AXIS_tdata      (tdata),
    .M_AXIS_tlast      (tlast),
    .M_AXIS_tready     (tready),
    .halt_cpu          (halt),
    .item_counter      (item_counter),
    .dropped_counter   (dropped_counter),
    .halted_cycles     (halted_cycles)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } item_t;

  item_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  int mon_tlast = 0;

  // reference model state
  int          m_mode;
  logic [63:0] m_lo, m_hi;
  int unsigned m_int, m_acc;
  bit          m_halt_en, m_valid, m_prev_we;
  int          m_cnt[NE];
  longint unsigned m_items, m_dropped, m_halted;

  // stimulus for the next step
  bit          s_pcv, s_rdy, s_we, s_en;
  logic [31:0] s_instr;
  logic [63:0] s_pc, s_data;
  logic [NE-1:0] s_ev;
  logic [7:0]  s_addr;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_lo = '0; m_hi = '1; m_int = 0; m_acc = 0;
    m_halt_en = 0; m_valid = 0; m_prev_we = 0;
    m_items = 0; m_dropped = 0; m_halted = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    q.delete();
  endfunction

  task automatic step();
    bit exp_valid, exp_halt, take;
    item_t it;
    @(posedge clk); #1;
    rst = 1'b0;
    pc_valid = s_pcv; instr = s_instr; pc = s_pc;
    performance_events = s_ev; tready = s_rdy; en = s_en;
    ctrl_write_enable = s_we; ctrl_addr = s_addr; ctrl_wdata = s_data;
    exp_valid = m_valid;
    exp_halt  = m_halt_en && (m_mode != 0) && m_valid && !s_rdy;
    if (exp_halt) m_halted++;
    if (m_valid && s_rdy) begin m_items++; m_valid = 0; end
    if (s_en)
      for (int i = 0; i < NE; i++)
        if (s_ev[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
    take = s_en && s_pcv &&
           (m_mode == 1 || (m_mode == 2 && s_pc >= m_lo && s_pc <= m_hi));
    if (take) begin
      if (!exp_valid || s_rdy) begin
        it.d = '0;
        it.d[31:0] = s_instr;
        it.d[32 +: XL] = s_pc;
        for (int i = 0; i < NE; i++) it.d[EVB + i*CW +: CW] = CW'(m_cnt[i]);
        m_acc++;
        it.l = (m_int != 0) && (m_acc % m_int == 0);
        q.push_back(it);
        m_valid = 1;
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else m_dropped++;
    end
    if (s_we && !m_prev_we) begin
      case (s_addr)
        8'd0: m_mode = int'(s_data[1:0]);
        8'd1: m_lo = s_data;
        8'd2: m_hi = s_data;
        8'd3: begin m_int = s_data[31:0]; m_acc = 0; end
        8'd4: m_halt_en = s_data[0];
        default: ;
      endcase
    end
    m_prev_we = s_we;
    @(negedge clk);
    chk("tvalid", 64'(tvalid), 64'(exp_valid));
    chk("halt_cpu", 64'(halt), 64'(exp_halt));
  endtask

  task automatic quiet(bit rdy);
    s_pcv = 0; s_ev = '0; s_we = 0; s_rdy = rdy; s_en = 1;
  endtask

  task automatic idle(int n, bit rdy = 1);
    quiet(rdy);
    repeat (n) step();
  endtask

  task automatic wr(logic [7:0] a, logic [63:0] d, bit rdy = 1);
    quiet(rdy);
    s_we = 1; s_addr = a; s_data = d;
    step();
    s_we = 0;
    step();
  endtask

  task automatic cap(logic [63:0] p, logic [NE-1:0] ev, bit rdy);
    quiet(rdy);
    s_pcv = 1; s_pc = p; s_ev = ev; s_instr = $urandom;
    step();
  endtask

  task automatic check_stats(string tag);
    chk({tag, "_items"}, item_counter, m_items);
    chk({tag, "_dropped"}, dropped_counter, m_dropped);
    chk({tag, "_halted"}, halted_cycles, m_halted);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; pc_valid = 0; performance_events = '0;
    ctrl_write_enable = 0; tready = 0;
    s_we = 0;
    @(negedge clk);
    chk("halt_in_reset", 64'(halt), 64'd0);
    model_reset();
  endtask

  // monitor: every presented beat must equal the oldest expected item
  always @(negedge clk) begin
    if (!rst && tvalid) begin
      if (q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_item got pc %0h expected none", tdata[32 +: XL]);
      end else begin
        n_checks++;
        if (tdata !== q[0].d || tlast !== q[0].l) begin
          n_errors++;
          $display("FAIL item got %h/%b expected %h/%b upper_nonzero=%b",
                   tdata[383:0], tlast, q[0].d[383:0], q[0].l, |tdata[DW-1:384]);
        end
        if (tready) begin
          if (tlast) mon_tlast++;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    longint unsigned hb, db, ib;
    int tl0;
    logic [63:0] evr;
    s_instr = '0; s_pc = '0; s_data = '0; s_addr = '0;
    quiet(1);
    model_reset();
    reset_dut();
    idle(2);
    chk("tdata_reset", 64'(|tdata), 64'd0);
    chk("tlast_reset", 64'(tlast), 64'd0);
    check_stats("reset");

    // three back-to-back items, event 0 each cycle
    wr(0, 1);
    ib = m_items;
    for (int i = 0; i < 3; i++) cap(64'h4000 + 64'(i*4), NE'(1), 1);
    idle(2);
    chk("b2b_items", item_counter, ib + 3);

    // saturation then empty snapshot
    quiet(1); s_ev = NE'(1);
    repeat (200) step();
    cap(64'h5000, '0, 1);
    cap(64'h5004, '0, 1);
    idle(2);

    // range filtering
    wr(1, 64'h1000); wr(2, 64'h1FFF); wr(0, 2);
    ib = m_items;
    cap(64'hFFF, '0, 1); cap(64'h1000, '0, 1);
    cap(64'h1FFF, '0, 1); cap(64'h2000, '0, 1);
    idle(2);
    chk("range_items", item_counter, ib + 2);

    // tlast every 4th item
    wr(0, 1); wr(3, 4);
    tl0 = mon_tlast;
    for (int i = 0; i < 10; i++) cap(64'h6000 + 64'(i), '0, 1);
    idle(2);
    chk("tlast_count", 64'(mon_tlast - tl0), 64'd2);
    wr(3, 0);

    // halt while stalled, one capture dropped
    wr(4, 1);
    hb = m_halted; db = m_dropped;
    cap(64'h7000, NE'(3), 0);
    idle(2, 0);
    cap(64'h7004, NE'(1), 0);
    idle(2, 0);
    idle(2, 1);
    chk("halted_cycles", halted_cycles, hb + 5);
    chk("dropped", dropped_counter, db + 1);
    wr(4, 0);
    check_stats("directed");

    // random traffic
    wr(1, 64'h100); wr(2, 64'h1C0); wr(0, 2);
    for (int n = 0; n < 1500; n++) begin
      s_pcv = ($urandom_range(0, 1) == 1);
      s_pc = 64'h0F0 + 64'($urandom_range(0, 'h100));
      s_instr = $urandom;
      evr = {$urandom, $urandom} & {$urandom, $urandom};
      s_ev = evr[NE-1:0];
      s_rdy = ($urandom_range(0, 9) < 7);
      s_en = ($urandom_range(0, 9) != 0);
      s_we = ($urandom_range(0, 14) == 0);
      s_addr = 8'($urandom_range(0, 5));
      case (s_addr)
        8'd0: s_data = 64'($urandom_range(1, 2));
        8'd1: s_data = 64'h100 + 64'($urandom_range(0, 'h20));
        8'd2: s_data = 64'h1A0 + 64'($urandom_range(0, 'h40));
        8'd3: s_data = 64'($urandom_range(0, 5));
        8'd4: s_data = 64'($urandom_range(0, 1));
        default: s_data = {$urandom, $urandom};
      endcase
      step();
    end
    idle(4);
    check_stats("random");

    // mode OFF with an item pending still delivers it
    wr(4, 0); wr(3, 0); wr(0, 1);
    ib = m_items;
    cap(64'h8000, '0, 0);
    wr(0, 0, 0);
    idle(3, 1);
    cap(64'h8004, '0, 1); cap(64'h8008, '0, 1);
    idle(2);
    chk("off_items", item_counter, ib + 1);

    // held write enable: only the first value lands
    quiet(1); s_we = 1; s_addr = 8'd0; s_data = 64'd1;
    step();
    s_data = 64'd0;
    repeat (9) step();
    s_we = 0;
    step();
    ib = m_items;
    cap(64'h9000, '0, 1); cap(64'h9004, '0, 1);
    idle(2);
    chk("held_we_items", item_counter, ib + 2);
    wr(4, 1);
    cap(64'h9008, '0, 0);
    idle(1, 0);
    reset_dut();
    idle(1, 0);
    chk("post_reset_tvalid", 64'(tvalid), 64'd0);
    chk("post_reset_items", item_counter, 64'd0);
    cap(64'hA000, '0, 1); cap(64'hA004, '0, 1);
    idle(3);
    check_stats("final");

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
